// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared widths, encodings and FSM state type for the
//                instruction fetch unit and the core that consumes it.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

  localparam int                  PC_W       = 12;
  localparam int                  INSTR_W    = 16;
  localparam int                  RET_W      = 16;
  localparam logic [PC_W-1:0]     RESET_PC   = 12'h000;
  localparam logic [INSTR_W-1:0]  HALT_INSTR = 16'hFFFF;

  // Fetch sequencer states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_EXEC  = 3'd4,
    S_HALT  = 3'd5
  } state_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Fetches one instruction at a time from instruction memory,
//                hands it to the core with a one-cycle run pulse, waits for
//                the core to finish, then advances or redirects the PC.
//                Fetching stops on the halt encoding.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter int                 PC_W       = fetch_pkg::PC_W,
  parameter int                 INSTR_W    = fetch_pkg::INSTR_W,
  parameter logic [PC_W-1:0]    RESET_PC   = fetch_pkg::RESET_PC,
  parameter logic [INSTR_W-1:0] HALT_INSTR = fetch_pkg::HALT_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic               run,
  input  logic               done,
  input  logic [PC_W-1:0]    new_pc,
  input  logic               en_new_pc,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic [15:0]        retired
);

  import fetch_pkg::*;

  state_t               r_state;
  logic [PC_W-1:0]      r_pc;
  logic [INSTR_W-1:0]   r_instr;
  logic                 r_imem_req;
  logic                 r_run;
  logic                 r_halted;
  logic [15:0]          r_retired;

  // Sequencer: state, PC, captured instruction, retire counter and the
  // registered strobes. Only one request can be outstanding because a new
  // request is issued solely from IDLE/HALT (start) or EXEC (done), never
  // while WAIT is still pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_imem_req <= 1'b0;
      r_run      <= 1'b0;
      r_halted   <= 1'b0;
      r_retired  <= '0;
    end else begin
      r_imem_req <= 1'b0;
      r_run      <= 1'b0;
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start) begin
            r_pc       <= RESET_PC;
            r_retired  <= '0;
            r_halted   <= 1'b0;
            r_imem_req <= 1'b1;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_valid) begin
            r_instr <= imem_rdata;
            if (imem_rdata == HALT_INSTR) begin
              // Halt word is captured but neither issued nor counted; pc
              // keeps pointing at it.
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end else begin
              r_run   <= 1'b1;
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          // A done coincident with run is deliberately not looked at here.
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (done) begin
            r_retired  <= r_retired + 16'd1;
            r_pc       <= en_new_pc ? new_pc : (r_pc + {{(PC_W-1){1'b0}}, 1'b1});
            r_imem_req <= 1'b1;
            r_state    <= S_REQ;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are straight register taps; the read address is the PC itself.
  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instruction = r_instr;
  assign run         = r_run;
  assign halted      = r_halted;
  assign retired     = r_retired;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. The bench plays both the
//                instruction memory and the core, and keeps an instruction-
//                level model (program counter, retire count, memory image).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [11:0] HALT_ADDR = 12'h800;

  logic        clk = 1'b0;
  logic        reset, start, imem_req, imem_valid, run, done, en_new_pc, halted;
  logic [11:0] imem_addr, new_pc, pc;
  logic [15:0] imem_rdata, instruction, retired;

  logic [15:0] mem [0:4095];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .PC_W       (12),
    .INSTR_W    (16),
    .RESET_PC   (12'h000),
    .HALT_INSTR (16'hFFFF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .instruction (instruction),
    .run         (run),
    .done        (done),
    .new_pc      (new_pc),
    .en_new_pc   (en_new_pc),
    .pc          (pc),
    .halted      (halted),
    .retired     (retired)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic quiet_inputs();
    start      = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = 16'($urandom);
    done       = 1'b0;
    en_new_pc  = 1'b0;
    new_pc     = 12'($urandom);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 4096; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      if (v == 16'hFFFF) v = 16'h0001;
      mem[i] = v;
    end
    mem[HALT_ADDR] = 16'hFFFF;
  endtask

  // Runs one program from start to halt. mode 0: straight-line program;
  // mode 1: scripted branches (pc 5 -> 0x040, then to 0xFFF to exercise wrap),
  // then random branches, finally a jump to the halt word.
  task automatic run_prog(input int lat_lo, input int lat_hi, input int dd_lo, input int dd_hi,
                          input bit spur, input int mode, input int max_instr);
    logic [11:0] m_pc, pend_addr, tgt;
    logic [15:0] m_ret;
    int  req_cd, exec_cd, since_trig, since_valid, n_instr, n_run;
    bit  outstanding, in_exec, halt_pend, fin, run_now, br;
    m_pc = 12'h000; m_ret = 16'h0; pend_addr = 12'h0;
    req_cd = 0; exec_cd = 0; n_instr = 0; n_run = 0; since_valid = 100;
    outstanding = 0; in_exec = 0; halt_pend = 0; fin = 0;

    @(posedge clk); #1;
    quiet_inputs();
    start = 1'b1;
    since_trig = 0;

    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      @(posedge clk); #1;
      quiet_inputs();
      since_trig++;
      since_valid++;
      run_now = 0;
      if (outstanding && req_cd > 0) req_cd--;
      if (in_exec && exec_cd > 0) exec_cd--;

      if (imem_req) begin
        check("req_latency", 32'(since_trig), 32'd1);
        check("req_addr", 32'(imem_addr), 32'(m_pc));
        check("req_retired", 32'(retired), 32'(m_ret));
        check("req_single_outstanding", 32'(outstanding), 32'd0);
        outstanding = 1;
        pend_addr   = imem_addr;
        req_cd      = $urandom_range(lat_hi, lat_lo);
      end
      if (run) begin
        check("run_latency", 32'(since_valid), 32'd1);
        check("run_instr", 32'(instruction), 32'(mem[m_pc]));
        check("run_not_halt", 32'(halt_pend), 32'd0);
        in_exec = 1;
        run_now = 1;
        exec_cd = $urandom_range(dd_hi, dd_lo);
        n_run++;
      end
      if (halt_pend && since_valid == 1) begin
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_pc", 32'(pc), 32'(m_pc));
        check("halt_retired", 32'(retired), 32'(m_ret));
        check("halt_instr", 32'(instruction), 32'hFFFF);
        check("run_count", 32'(n_run), 32'(m_ret));
        fin = 1;
      end

      if (!fin) begin
        // memory side
        if (outstanding && req_cd == 0) begin
          imem_valid  = 1'b1;
          imem_rdata  = mem[pend_addr];
          outstanding = 0;
          since_valid = 0;
          if (mem[pend_addr] == 16'hFFFF) halt_pend = 1;
        end else if (spur && !outstanding && $urandom_range(0, 2) == 0) begin
          imem_valid = 1'b1;
        end
        // core side
        if (in_exec && !run_now && exec_cd == 0) begin
          br  = 0;
          tgt = 12'($urandom);
          if (mode == 1) begin
            if (n_instr >= max_instr)                   begin br = 1; tgt = HALT_ADDR; end
            else if (m_pc == 12'h005)                   begin br = 1; tgt = 12'h040;   end
            else if (n_instr == 8)                      begin br = 1; tgt = 12'hFFF;   end
            else if (n_instr > 10 && $urandom_range(0, 3) == 0) br = 1;
          end
          done      = 1'b1;
          en_new_pc = br;
          new_pc    = tgt;
          m_pc      = br ? tgt : 12'((32'(m_pc) + 1) % 4096);
          m_ret     = m_ret + 16'd1;
          in_exec   = 0;
          since_trig = 0;
          n_instr++;
        end else if (spur && (!in_exec || run_now) && $urandom_range(0, 2) == 0) begin
          done      = 1'b1;
          en_new_pc = 1'b1;
        end
        if (spur && $urandom_range(0, 7) == 0) start = 1'b1;
      end
    end
    check("program_terminated", 32'(fin), 32'd1);
    quiet_inputs();
  endtask

  initial begin
    // reset with every other input active: reset must win
    reset = 1'b1; start = 1'b1; imem_valid = 1'b1; imem_rdata = 16'h1234;
    done = 1'b1; en_new_pc = 1'b1; new_pc = 12'h123;
    repeat (2) @(posedge clk);
    #1;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_run", 32'(run), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc", 32'(pc), 32'h000);
    check("rst_instruction", 32'(instruction), 32'h0);
    check("rst_retired", 32'(retired), 32'h0);
    reset = 1'b0;
    quiet_inputs();
    @(posedge clk); #1;
    check("idle_no_req", 32'(imem_req), 32'd0);

    // straight-line program: 1111, 2222, halt
    fill_mem();
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'hFFFF;
    run_prog(1, 1, 2, 2, 0, 0, 0);
    check("linear_pc", 32'(pc), 32'h002);
    check("linear_retired", 32'(retired), 32'd2);

    // restart from HALT, branches + wrap, random latencies
    fill_mem();
    run_prog(1, 3, 1, 3, 0, 1, 25);

    // 4-cycle memory with spurious valid/done/start pulses
    fill_mem();
    run_prog(4, 4, 1, 4, 1, 1, 15);

    // reset while WAIT has a response pending, then late valid
    @(posedge clk); #1;
    quiet_inputs();
    start = 1'b1;
    @(posedge clk); #1;
    quiet_inputs();
    check("wait_rst_req", 32'(imem_req), 32'd1);
    @(posedge clk); #1;
    quiet_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    quiet_inputs();
    reset = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 16'h1234;
    check("wait_rst_instr", 32'(instruction), 32'h0);
    check("wait_rst_halted", 32'(halted), 32'd0);
    check("wait_rst_pc", 32'(pc), 32'h000);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      quiet_inputs();
      check("late_valid_run", 32'(run), 32'd0);
      check("late_valid_instr", 32'(instruction), 32'h0);
      check("late_valid_req", 32'(imem_req), 32'd0);
    end

    // restart from IDLE after the aborted fetch
    fill_mem();
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'hFFFF;
    run_prog(1, 2, 1, 2, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, 12, program-counter width; SHALL match the core's new_pc width.
REQ-002 Parameter INSTR_W, 16, instruction width.
REQ-003 Parameter RESET_PC, 12'h000, first fetch address after start.
REQ-004 Parameter HALT_INSTR, 16'hFFFF, encoding that stops fetching.
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 start  in  1  begin fetching from RESET_PC; sampled only in IDLE or HALT.
REQ-008 imem_req  out  1  one-cycle read strobe to instruction memory.
REQ-009 imem_addr  out  PC_W  read address, equal to pc whenever imem_req=1.
REQ-010 imem_rdata  in  INSTR_W  read data.
REQ-011 imem_valid  in  1  imem_rdata valid; latency is 1 or more cycles after imem_req.
REQ-012 instruction  out  INSTR_W  registered instruction to the core; held stable from ISSUE until the next fetch completes.
REQ-013 run  out  1  one-cycle pulse telling the core to execute instruction.
REQ-014 done  in  1  core finished the current instruction.
REQ-015 new_pc  in  PC_W  branch target from the core.
REQ-016 en_new_pc  in  1  branch redirect valid; sampled only together with done.
REQ-017 pc  out  PC_W  current program counter.
REQ-018 halted  out  1  high while in HALT.
REQ-019 retired  out  16  count of completed instructions.

Function
REQ-020 FSM states: IDLE, REQ, WAIT, ISSUE, EXEC, HALT.
REQ-021 IDLE: start=1 loads pc=RESET_PC and clears retired; next state is REQ.
REQ-022 REQ: imem_req=1 for exactly one cycle; next state is WAIT.
REQ-023 WAIT: on imem_valid=1, imem_rdata is captured into instruction; next state is HALT if the data equals HALT_INSTR, else ISSUE.
REQ-024 ISSUE: run=1 for exactly one cycle; next state is EXEC.
REQ-025 EXEC: on done=1, retired increments and the next state is REQ.
REQ-026 EXEC: on done=1 with en_new_pc=1, pc becomes new_pc; with en_new_pc=0, pc becomes pc+1.
REQ-027 pc+1 SHALL wrap modulo 2^PC_W: 12'hFFF -> 12'h000. retired SHALL wrap 16'hFFFF -> 0.
REQ-028 HALT: halted=1 and pc holds the halt address; the HALT instruction SHALL NOT be issued or counted.
REQ-029 HALT: start=1 behaves as in IDLE (REQ-021).
REQ-030 imem_valid outside WAIT, done outside EXEC, and start outside IDLE/HALT SHALL be ignored.
REQ-031 done arriving in the same cycle as run SHALL NOT be accepted; it is accepted from the following cycle only.
REQ-032 Latency: start at cycle 0 -> imem_req at cycle 1 -> (1-cycle memory) valid at cycle 2 -> run at cycle 3.
REQ-033 At most one memory request SHALL be outstanding at any time.

Reset
REQ-034 reset=1 at a clock edge SHALL force: state=IDLE, pc=RESET_PC, instruction=0, run=0, imem_req=0, halted=0, retired=0.
REQ-035 reset SHALL take priority over every other input.
REQ-036 Reset in any state, including WAIT with a memory response pending, SHALL return the block to IDLE; a late imem_valid SHALL then be discarded.

Structure
REQ-037 A shared package fetch_pkg SHALL hold the state enum and the PC_W, INSTR_W, RESET_PC and HALT_INSTR constants; the core SHALL reuse PC_W and INSTR_W from it.
REQ-038 No sub-module is needed: the FSM, pc register and retired counter live in one module.

Verification
REQ-039 Linear program: memory 0:1111, 1:2222, 2:FFFF with 1-cycle latency, core done 2 cycles after run -> instructions 1111 then 2222 issued, halted=1, pc=2, retired=2.
REQ-040 Branch: done with en_new_pc=1 and new_pc=0x040 at pc=5 -> next imem_addr=0x040 and retired increments by 1.
REQ-041 Wrap: pc=0xFFF, done with en_new_pc=0 -> next imem_addr=0x000.
REQ-042 Memory latency 4 cycles, with spurious imem_valid/done pulses in ISSUE -> no extra run pulses and no second imem_req while one is pending.
REQ-043 Reset in WAIT, then imem_valid arrives next cycle -> state IDLE, instruction=0, run stays 0; start then restarts at 0x000.
REQ-044 Restart from HALT via start -> retired=0, imem_addr=RESET_PC one cycle later.
